// File: rtl/count_change_fifo.sv
// ============================================================================
// Module      : count_change_fifo
// Description : Samples a counter value, queues every distinct value in a
//               small FIFO drained over valid/ready; counts dropped pushes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_change_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  in_count,
  input  logic          in_en,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [7:0]    drop_cnt
);

  localparam logic [AW:0] c_full     = (AW+1)'(DEPTH);
  localparam logic [7:0]  c_drop_max = 8'hff;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [W-1:0]  r_prev;
  logic          r_primed;
  logic          r_overflow;
  logic [7:0]    r_drop_cnt;

  logic w_want;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  always_comb begin
    w_want = in_en && (!r_primed || (in_count != r_prev));
    w_full = (r_level == c_full);
    w_pop  = (r_level != '0) && out_ready;
    // When full, a simultaneous pop frees the slot this push lands in.
    w_push = w_want && (!w_full || w_pop);
    w_drop = w_want && w_full && !w_pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_prev     <= '0;
      r_primed   <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      // prev tracks every enabled sample, even dropped ones, so no retry.
      if (in_en) begin
        r_prev   <= in_count;
        r_primed <= 1'b1;
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_count;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - (AW+1)'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != c_drop_max) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign out_data  = r_mem[r_rd_ptr];
  assign out_valid = (r_level != '0);
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire
